encoder_menu_ctrl: RTL and testbench

- Controller that shares one quadrature encoder and its push-button between NUM_CH setpoint registers.
- Consumes the giroPositivo/giroNegativo level outputs of the existing encoder decoder and a raw button.
- Runs a two-mode FSM: BROWSE (rotation selects a channel) and EDIT (rotation changes the selected channel's value).
- Feeds setpoints to downstream PWM/display blocks.

---
 rtl/encoder_menu_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_encoder_menu_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_menu_ctrl.sv
// Shares one quadrature encoder + push-button between NUM_CH setpoint registers.
// BROWSE mode picks a channel with rotation; EDIT mode steps that channel's value.

module encoder_menu_ch #(
  parameter int N         = 7,
  parameter int MAX_COUNT = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [N-1:0] val_o,
  output logic         chg_o
);
  localparam logic [N-1:0] MAXV = N'(MAX_COUNT);

  logic [N-1:0] val_q, val_d;

  // Saturating step; a step against a rail leaves the register untouched.
  always_comb begin
    val_d = val_q;
    if (inc_i && (val_q != MAXV))      val_d = val_q + 1'b1;
    else if (dec_i && (val_q != '0))   val_d = val_q - 1'b1;
  end

  assign chg_o = (val_d != val_q);
  assign val_o = val_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end
endmodule

module encoder_menu_ctrl #(
  parameter int N               = 7,
  parameter int MAX_COUNT       = 31,
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      giro_pos,
  input  logic                      giro_neg,
  input  logic                      btn,
  output logic [$clog2(NUM_CH)-1:0] canal_sel,
  output logic                      modo_edit,
  output logic [NUM_CH*N-1:0]       valores,
  output logic [N-1:0]              valor_act,
  output logic                      cambio
);
  localparam int SW = $clog2(NUM_CH);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] LAST  = SW'(NUM_CH - 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {BROWSE = 1'b0, EDIT = 1'b1} state_e;

  // Step edge detection; delay regs reset high so a level held through reset is not a step.
  logic gp_d_q, gn_d_q;
  logic step_up, step_dn, step_up_v, step_dn_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gp_d_q <= 1'b1;
      gn_d_q <= 1'b1;
    end else begin
      gp_d_q <= giro_pos;
      gn_d_q <= giro_neg;
    end
  end

  assign step_up   = giro_pos & ~gp_d_q;
  assign step_dn   = giro_neg & ~gn_d_q;
  assign step_up_v = step_up & ~step_dn;
  assign step_dn_v = step_dn & ~step_up;

  // Button: 2-FF synchronizer, stability counter, registered rising-edge detect.
  logic btn_s1_q, btn_s2_q;
  logic db_q, db_d, db_prev_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic press;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (btn_s2_q != db_q) begin
      if (db_cnt_q == DLAST) db_d     = btn_s2_q;
      else                   db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      db_cnt_q  <= '0;
    end else begin
      btn_s1_q  <= btn;
      btn_s2_q  <= btn_s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      db_cnt_q  <= db_cnt_d;
    end
  end

  assign press = db_q & ~db_prev_q;

  // Mode FSM, channel selection and inactivity timeout.
  state_e        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [TW-1:0] to_q, to_d;
  logic          edit_inc, edit_dec;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    to_d     = to_q;
    edit_inc = 1'b0;
    edit_dec = 1'b0;
    case (state_q)
      BROWSE: begin
        to_d = '0;
        if (press)          state_d = EDIT;
        else if (step_up_v) sel_d = (sel_q == LAST) ? '0 : sel_q + 1'b1;
        else if (step_dn_v) sel_d = (sel_q == '0) ? LAST : sel_q - 1'b1;
      end
      EDIT: begin
        // Activity outranks an expiring timeout; press outranks everything.
        if (press) begin
          state_d = BROWSE;
        end else if (step_up || step_dn) begin
          to_d     = '0;
          edit_inc = step_up_v;
          edit_dec = step_dn_v;
        end else if (to_q == TLAST) begin
          state_d = BROWSE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = BROWSE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BROWSE;
      sel_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      to_q    <= to_d;
    end
  end

  // Per-channel setpoint registers.
  logic [NUM_CH-1:0][N-1:0] vals;
  logic [NUM_CH-1:0]        ch_inc, ch_dec, ch_chg;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_inc[g] = edit_inc && (sel_q == SW'(g));
    assign ch_dec[g] = edit_dec && (sel_q == SW'(g));
    encoder_menu_ch #(.N(N), .MAX_COUNT(MAX_COUNT)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .inc_i (ch_inc[g]),
      .dec_i (ch_dec[g]),
      .val_o (vals[g]),
      .chg_o (ch_chg[g])
    );
  end

  logic cambio_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cambio_q <= 1'b0;
    else     cambio_q <= |ch_chg;
  end

  assign canal_sel = sel_q;
  assign modo_edit = (state_q == EDIT);
  assign valores   = vals;
  assign valor_act = vals[sel_q];
  assign cambio    = cambio_q;
endmodule

// File: tb/tb_encoder_menu_ctrl.sv
// Bench for encoder_menu_ctrl: directed test-plan scenarios plus random encoder/button
// activity, all checked every cycle against a behavioural model of the menu.

module tb_encoder_menu_ctrl;
  localparam int N    = 7;
  localparam int MAXC = 31;
  localparam int NCH  = 4;
  localparam int DEB  = 4;
  localparam int TO   = 20;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   giro_pos = 1'b0, giro_neg = 1'b0, btn = 1'b0;
  logic [$clog2(NCH)-1:0] canal_sel;
  logic                   modo_edit, cambio;
  logic [NCH*N-1:0]       valores;
  logic [N-1:0]           valor_act;

  encoder_menu_ctrl #(.N(N), .MAX_COUNT(MAXC), .NUM_CH(NCH),
                      .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .giro_pos(giro_pos), .giro_neg(giro_neg), .btn(btn),
    .canal_sel(canal_sel), .modo_edit(modo_edit), .valores(valores),
    .valor_act(valor_act), .cambio(cambio)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0, nchg = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      if (nfail <= 30) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: button is accepted once the synchronized level has disagreed
  // with the accepted level for DEB consecutive samples; the press acts one cycle later.
  int mv [NCH];
  int msel = 0, midle = 0;
  bit medit = 0, mcam = 0, bh0 = 0, bh1 = 0, gpp = 1, gnp = 1, mdeb = 0, mrise = 0;
  bit sq [$];
  bit m_sync, m_press, m_up, m_dn, m_flip;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (mv[i]) mv[i] = 0;
      msel = 0; midle = 0; medit = 0; mcam = 0;
      bh0 = 0; bh1 = 0; gpp = 1; gnp = 1; mdeb = 0; mrise = 0;
      sq.delete();
    end else begin
      m_sync  = bh1;
      m_press = mrise;
      m_up    = giro_pos && !gpp;
      m_dn    = giro_neg && !gnp;
      sq.push_back(m_sync);
      if (sq.size() > DEB) void'(sq.pop_front());
      m_flip = (sq.size() == DEB);
      foreach (sq[i]) if (sq[i] == mdeb) m_flip = 0;
      mrise = m_flip && !mdeb;
      if (m_flip) mdeb = !mdeb;
      bh1 = bh0; bh0 = btn; gpp = giro_pos; gnp = giro_neg;
      mcam = 0;
      if (!medit) begin
        if (m_press) begin medit = 1; midle = 0; end
        else if (m_up && !m_dn) msel = (msel + 1) % NCH;
        else if (m_dn && !m_up) msel = (msel + NCH - 1) % NCH;
      end else begin
        if (m_press) medit = 0;
        else if (m_up || m_dn) begin
          midle = 0;
          if (m_up && !m_dn && mv[msel] < MAXC) begin mv[msel]++; mcam = 1; end
          if (m_dn && !m_up && mv[msel] > 0)    begin mv[msel]--; mcam = 1; end
        end
        else if (midle == TO - 1) medit = 0;
        else midle++;
      end
    end
  end

  logic [NCH*N-1:0] ev;
  always @(negedge clk) begin
    if (cambio === 1'b1) nchg++;
    if (chk_en) begin
      for (int i = 0; i < NCH; i++) ev[i*N +: N] = N'(mv[i]);
      chk("canal_sel", longint'(canal_sel), longint'(msel));
      chk("modo_edit", longint'(modo_edit), longint'(medit));
      chk("valores",   longint'(valores),   longint'(ev));
      chk("valor_act", longint'(valor_act), longint'(mv[msel]));
      chk("cambio",    longint'(cambio),    longint'(mcam));
    end
  end

  function automatic int chv(input int i);
    return int'(valores[i*N +: N]);
  endfunction

  task automatic pulse(input bit up);
    if (up) giro_pos = 1'b1; else giro_neg = 1'b1;
    @(negedge clk);
    giro_pos = 1'b0; giro_neg = 1'b0;
    @(negedge clk);
  endtask

  // Holds btn until EDIT is seen (bounded), releases it, returns the latency in cycles.
  task automatic enter_edit(output int lat);
    btn = 1'b1;
    lat = 0;
    while (!modo_edit && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    btn = 1'b0;
  endtask

  task automatic cycles_to_exit(output int n);
    n = 0;
    while (modo_edit && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  int lat, base, n, hold;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset_valores", longint'(valores), 0);
    chk("reset_sel", longint'(canal_sel), 0);
    chk("reset_mode", longint'(modo_edit), 0);

    // BROWSE wrap-around selection
    base = nchg;
    for (int i = 0; i < 5; i++) pulse(1'b1);
    chk("browse_sel_after5", longint'(canal_sel), 1);
    chk("browse_vals", longint'(valores), 0);
    chk("browse_cambio_cnt", nchg - base, 0);

    // Edit ch2 by 3
    pulse(1'b1);
    chk("sel_ch2", longint'(canal_sel), 2);
    enter_edit(lat);
    chk("press_latency", lat, 7);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    base = nchg;
    for (int i = 0; i < 3; i++) pulse(1'b1);
    chk("ch2_val3", chv(2), 3);
    chk("ch2_cambio3", nchg - base, 3);
    chk("others_zero", chv(0) + chv(1) + chv(3), 0);

    // Saturation both ways
    base = nchg;
    for (int i = 0; i < 40; i++) pulse(1'b1);
    chk("sat_hi", chv(2), 31);
    chk("sat_hi_cambio", nchg - base, 28);
    base = nchg;
    for (int i = 0; i < 35; i++) pulse(1'b0);
    chk("sat_lo", chv(2), 0);
    chk("sat_lo_cambio", nchg - base, 31);

    // Glitch rejected; press coincident with a step
    pulse(1'b0);
    btn = 1'b1;
    repeat (2) @(negedge clk);
    btn = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch_mode", longint'(modo_edit), 1);
    btn = 1'b1;
    repeat (6) @(negedge clk);
    giro_pos = 1'b1;
    @(negedge clk);
    giro_pos = 1'b0;
    chk("press_step_mode", longint'(modo_edit), 0);
    chk("press_step_val", chv(2), 0);
    chk("press_step_sel", longint'(canal_sel), 2);
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);

    // Timeout
    enter_edit(lat);
    cycles_to_exit(n);
    chk("timeout_cycles", n, 20);
    enter_edit(lat);
    repeat (19) @(negedge clk);
    giro_pos = 1'b1;
    @(negedge clk);
    giro_pos = 1'b0;
    chk("late_step_mode", longint'(modo_edit), 1);
    chk("late_step_val", chv(2), 1);
    cycles_to_exit(n);
    chk("timeout_restart", n, 20);
    chk("timeout_keep_val", chv(2), 1);

    // Simultaneous steps, then reset mid-EDIT
    giro_pos = 1'b1; giro_neg = 1'b1;
    @(negedge clk);
    giro_pos = 1'b0; giro_neg = 1'b0;
    @(negedge clk);
    chk("both_browse_sel", longint'(canal_sel), 2);
    pulse(1'b0);
    enter_edit(lat);
    for (int i = 0; i < 17; i++) pulse(1'b1);
    chk("ch1_val17", chv(1), 17);
    giro_pos = 1'b1; giro_neg = 1'b1;
    @(negedge clk);
    giro_pos = 1'b0; giro_neg = 1'b0;
    @(negedge clk);
    chk("both_edit_val", chv(1), 17);
    #2 rst = 1'b1;
    #1;
    chk("rst_vals", longint'(valores), 0);
    chk("rst_mode", longint'(modo_edit), 0);
    chk("rst_sel", longint'(canal_sel), 0);
    chk("rst_cambio", longint'(cambio), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Random activity against the model
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) giro_pos = ~giro_pos;
      if ($urandom_range(0, 3) == 0) giro_neg = ~giro_neg;
      if (hold > 0) begin
        hold--;
        if (hold == 0) btn = 1'b0;
      end else if ($urandom_range(0, 24) == 0) begin
        btn  = 1'b1;
        hold = $urandom_range(1, 12);
      end
      if (c == 1500) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
